// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter: state encoding,
// default requester count and a constant-friendly ceil(log2) helper.
package arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Binary index to one-hot vector; an index with no matching output decodes
// to all zeros so no unknown value can leak onto the enables.
module onehot_decode #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IDX_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with hold-until-release grants, binary and one-hot grant.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int IDX_W    = clog2(NUM_REQ),
  parameter int HOLD_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               release_i,
  output logic               gnt_valid_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic [NUM_REQ-1:0] gnt_onehot_o,
  output logic               timeout_o,
  output logic               state_o
);

  arb_state_e           state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [NUM_REQ-1:0]   masked;
  logic [NUM_REQ-1:0]   search;
  logic [IDX_W-1:0]     winner;
  logic                 found;
  logic [NUM_REQ-1:0]   winner_onehot;
  logic                 owner_done;

  assign state_o = state_q;

  // Requests strictly above the pointer win first; otherwise wrap to bit 0.
  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req_i[i] && (i > int'(ptr_q));
    end
    search = (masked != '0) ? masked : req_i;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && search[i]) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end

  onehot_decode #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_decode (
    .idx   (winner),
    .onehot(winner_onehot)
  );

  assign owner_done = release_i || !req_i[gnt_idx_o];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  assign timeout_o = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      gnt_valid_o  <= 1'b0;
      gnt_idx_o    <= '0;
      gnt_onehot_o <= '0;
      hold_cnt     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i != '0) begin
            state_q      <= ST_BUSY;
            gnt_valid_o  <= 1'b1;
            gnt_idx_o    <= winner;
            gnt_onehot_o <= winner_onehot;
            ptr_q        <= winner;
            hold_cnt     <= '0;
          end
        end
        default: begin
          // A normal release beats the timeout and suppresses the pulse.
          if (owner_done || hold_cnt == CNT_W'(HOLD_MAX - 1)) begin
            state_q      <= ST_IDLE;
            gnt_valid_o  <= 1'b0;
            gnt_idx_o    <= '0;
            gnt_onehot_o <= '0;
            timeout_q    <= !owner_done;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end
`else
  assign timeout_o = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      gnt_valid_o  <= 1'b0;
      gnt_idx_o    <= '0;
      gnt_onehot_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i != '0) begin
            state_q      <= ST_BUSY;
            gnt_valid_o  <= 1'b1;
            gnt_idx_o    <= winner;
            gnt_onehot_o <= winner_onehot;
            ptr_q        <= winner;
          end
        end
        default: begin
          if (owner_done) begin
            state_q      <= ST_IDLE;
            gnt_valid_o  <= 1'b0;
            gnt_idx_o    <= '0;
            gnt_onehot_o <= '0;
          end
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter; the ARB_TIMEOUT_EN section runs only
// when the macro is defined (HOLD_MAX is then shortened to 8).
module tb_rr_onehot_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 255;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] req_i;
  logic        release_i;
  logic        gnt_valid_o;
  logic [3:0]  gnt_idx_o;
  logic [15:0] gnt_onehot_o;
  logic        timeout_o;
  logic        state_o;

  int pass_cnt;
  int total_cnt;

  rr_onehot_arbiter #(
    .NUM_REQ (16),
    .IDX_W   (4),
    .HOLD_MAX(HOLD),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .release_i   (release_i),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_onehot_o(gnt_onehot_o),
    .timeout_o   (timeout_o),
    .state_o     (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle outputs before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic valid, input int idx, input logic to);
    logic [15:0] exp_oh;
    exp_oh = valid ? (16'h1 << idx) : 16'h0;
    check({tag, ".valid"}, 32'(gnt_valid_o), 32'(valid));
    check({tag, ".idx"}, 32'(gnt_idx_o), valid ? 32'(idx) : 32'h0);
    check({tag, ".onehot"}, 32'(gnt_onehot_o), 32'(exp_oh));
    check({tag, ".state"}, 32'(state_o), 32'(valid));
    check({tag, ".timeout"}, 32'(timeout_o), 32'(to));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    req_i     = 16'h0;
    release_i = 1'b0;
    #1;
    check_grant("reset", 1'b0, 0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // 1: idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      check_grant("idle_noreq", 1'b0, 0, 1'b0);
    end

    // 2: single requester, release after 3 busy cycles, re-grant after gap
    req_i = 16'h0010;
    tick();
    check_grant("single_grant", 1'b1, 4, 1'b0);
    tick();
    check_grant("single_hold1", 1'b1, 4, 1'b0);
    tick();
    check_grant("single_hold2", 1'b1, 4, 1'b0);
    release_i = 1'b1;
    tick();
    check_grant("single_release", 1'b0, 0, 1'b0);
    release_i = 1'b0;
    tick();
    check_grant("single_regrant", 1'b1, 4, 1'b0);
    req_i = 16'h0;
    tick();
    check_grant("single_drop", 1'b0, 0, 1'b0);
    release_i = 1'b1;
    tick();
    check_grant("release_in_idle", 1'b0, 0, 1'b0);
    release_i = 1'b0;

    // 3: fairness with all requests and release every busy cycle
    do_reset();
    req_i     = 16'hFFFF;
    release_i = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      check_grant($sformatf("rotate_g%0d", k), 1'b1, k % 16, 1'b0);
      tick();
      check_grant($sformatf("rotate_i%0d", k), 1'b0, 0, 1'b0);
    end
    release_i = 1'b0;
    req_i     = 16'h0;

    // 4: wrap-around from pointer 14, release racing a new request
    req_i = 16'h4000;
    tick();
    check_grant("ptr14_grant", 1'b1, 14, 1'b0);
    req_i = 16'h0;
    tick();
    check_grant("ptr14_drop", 1'b0, 0, 1'b0);
    req_i = 16'h0005;
    tick();
    check_grant("wrap_grant0", 1'b1, 0, 1'b0);
    release_i = 1'b1;
    tick();
    check_grant("wrap_release", 1'b0, 0, 1'b0);
    release_i = 1'b0;
    tick();
    check_grant("wrap_grant2", 1'b1, 2, 1'b0);
    req_i = 16'h0;
    tick();
    check_grant("wrap_drop", 1'b0, 0, 1'b0);

    // 5: non-owner ignored, owner drop, async reset mid-busy
    req_i = 16'h0008;
    tick();
    check_grant("own3_grant", 1'b1, 3, 1'b0);
    req_i = 16'h0009;
    tick();
    check_grant("own3_ignore", 1'b1, 3, 1'b0);
    req_i = 16'h0001;
    tick();
    check_grant("own3_drop", 1'b0, 0, 1'b0);
    tick();
    check_grant("after_drop_grant0", 1'b1, 0, 1'b0);
    req_i = 16'h0011;
    #2;
    reset = 1'b1;
    #1;
    check_grant("async_reset", 1'b0, 0, 1'b0);
    tick();
    check_grant("reset_held", 1'b0, 0, 1'b0);
    reset = 1'b0;
    tick();
    check_grant("post_reset_grant0", 1'b1, 0, 1'b0);
    req_i = 16'h0;
    tick();
    check_grant("post_reset_drop", 1'b0, 0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // 6: forced release after HOLD_MAX busy cycles
    do_reset();
    req_i = 16'h0003;
    tick();
    check_grant("to_grant0", 1'b1, 0, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      tick();
      check_grant($sformatf("to_hold%0d", c), 1'b1, 0, 1'b0);
    end
    tick();
    check_grant("to_forced", 1'b0, 0, 1'b1);
    tick();
    check_grant("to_next_grant1", 1'b1, 1, 1'b0);
    req_i = 16'h0;
    tick();
    check_grant("to_drop", 1'b0, 0, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
Round-robin arbiter that shares one resource between NUM_REQ requesters. A granted requester holds the resource until it releases it.
- Grant is presented two ways: a binary index, and a one-hot vector produced by an internal binary-to-one-hot decoder.
- Sits in front of a shared datapath; the one-hot grant drives its per-requester mux/enables directly.

Parameters:
NUM_REQ, 16, number of requesters; power of two, 2..16.
IDX_W, 4, binary index width; equals log2(NUM_REQ).
HOLD_MAX, 255, maximum grant length in cycles; used only with ARB_TIMEOUT_EN.
CNT_W, 8, hold-counter width; must hold HOLD_MAX.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_i  input  NUM_REQ  request vector; bit n = requester n wants the resource.
release_i  input  1  current owner is done; sampled only in BUSY.
gnt_valid_o  output  1  a grant is active.
gnt_idx_o  output  IDX_W  binary index of the owner; 0 when gnt_valid_o=0.
gnt_onehot_o  output  NUM_REQ  one-hot owner; all zeros when gnt_valid_o=0.
timeout_o  output  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- One clock and an asynchronous, active-high reset.
- Reset state: all outputs 0, state=IDLE, ptr_q=NUM_REQ-1 (so the first search starts at requester 0), hold counter 0.
- Asserting reset mid-grant drops the grant immediately (asynchronous). The pointer returns to NUM_REQ-1.
- All outputs are registered. The decoder output is registered together with gnt_idx_o, so the two never disagree.
- FSM, 2 states:
  - IDLE: if req_i==0, stay.
    - Otherwise the winner is the first set bit searching ptr_q+1, ptr_q+2, ... modulo NUM_REQ.
    - Next edge: state=BUSY, gnt_valid_o=1, gnt_idx_o=winner, gnt_onehot_o=1<<winner, ptr_q=winner.
    - Latency from request to grant is 1 cycle.
  - BUSY: the grant is held unchanged while release_i=0 and req_i[gnt_idx_o]=1.
    - Release condition: release_i=1, or the owner drops its request bit.
    - On release, next edge: state=IDLE, gnt_valid_o=0, index and one-hot = 0.
    - Minimum gap between two grants is 1 idle cycle.
- Requests from non-owners during BUSY are ignored; they are evaluated in the following IDLE cycle.
- Same-cycle release and new requests: release wins. The new requests are arbitrated in the next IDLE cycle.
- Wrap-around: ptr_q=NUM_REQ-1 searches from 0. Only a single requester active means it is re-granted after each 1-cycle gap.
- Fairness: with all bits of req_i held high, grants rotate 0,1,...,NUM_REQ-1,0,...
- release_i while IDLE has no effect.
- Bits of req_i at or above NUM_REQ do not exist; no X propagation is allowed. The decoder default produces all zeros.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - The hold counter clears on grant and increments each BUSY cycle.
  - When the counter reaches HOLD_MAX-1 without a release, the FSM forces a release: next edge goes to IDLE and timeout_o pulses for 1 cycle.
  - ptr_q keeps the timed-out index, so that requester gets lowest priority next.
  - A normal release in the same cycle takes precedence; no timeout_o pulse.
- Undefined: no counter is built, timeout_o is tied 0, and a grant can be held indefinitely.

Decomposition:
- Shared package arb_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1.
  - constant DEF_NUM_REQ=16.
  - function clog2 for IDX_W.
- One sub-module, onehot_decode, is natural:
  - parameterised binary-to-one-hot converter (IDX_W in, NUM_REQ out), purely combinational.
  - drives the input of the gnt_onehot_o register.
- Priority rotation (mask above ptr_q, then fall back to the unmasked vector) stays in the top level.

Test Plan:
1. Release reset with req_i=16'h0000 for 5 cycles -> gnt_valid_o=0, gnt_idx_o=0, gnt_onehot_o=0 throughout.
2. req_i=16'h0010 held, release_i pulse after 3 BUSY cycles -> gnt_idx_o=4 and gnt_onehot_o=16'h0010 one cycle after the request. The grant lasts exactly until the edge after release_i, followed by 1 idle cycle, then re-grant of index 4.
3. req_i=16'hFFFF constant, release_i=1 every BUSY cycle -> gnt_idx_o sequence 0,1,2,...,15,0 with gnt_onehot_o=1<<idx each time.
4. ptr_q=14 (after a grant to 14), req_i=16'h0005 -> winner 0 (wrap), then 2 on the next arbitration.
5. Owner 3 drops req_i[3] while release_i=0 -> grant removed next edge. Assert reset mid-BUSY -> outputs 0 immediately, next grant searches from 0.
6. ARB_TIMEOUT_EN with HOLD_MAX=8, req_i=16'h0003, no release -> requester 0 is forced off after 8 BUSY cycles with timeout_o=1 for 1 cycle, and the next grant goes to requester 1.
